// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master serial arbitration link:
// port FSM states and the serial symbol patterns the arbiter also decodes.
package bus_arb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    ID,
    WAIT_GNT,
    ACK,
    NAK,
    WAIT_COM,
    XFER,
    END,
    WAIT_REL
  } port_state_t;

  localparam logic [2:0] SYM_REQ = 3'b111;
  localparam logic [2:0] SYM_ACK = 3'b101;
  localparam logic [2:0] SYM_NAK = 3'b110;
  localparam logic [1:0] SYM_END = 2'b01;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sym_shifter.sv
// Loadable parallel-to-serial symbol register, MSB first, with a registered
// line output and flags marking the final and next-to-final bits.
module sym_shifter #(
  parameter int W     = 3,
  parameter int LEN_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [W-1:0]     sym,
  input  logic [LEN_W-1:0] len,
  output logic             line,
  output logic             last_bit,
  output logic             penult
);

  logic [W-1:0]     data_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic             line_reg;
  logic             last_reg;
  logic [W-1:0]     aligned;

  // Left-align the symbol so its first bit always sits at the MSB.
  assign aligned = sym << (LEN_W'(W) - len);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_reg <= '0;
      cnt_reg  <= '0;
      line_reg <= 1'b0;
      last_reg <= 1'b0;
    end else if (load) begin
      line_reg <= aligned[W-1];
      data_reg <= aligned << 1;
      cnt_reg  <= len - LEN_W'(1);
      last_reg <= (len == LEN_W'(1));
    end else if (cnt_reg != '0) begin
      line_reg <= data_reg[W-1];
      data_reg <= data_reg << 1;
      cnt_reg  <= cnt_reg - LEN_W'(1);
      last_reg <= (cnt_reg == LEN_W'(1));
    end else begin
      line_reg <= 1'b0;
      last_reg <= 1'b0;
    end
  end

  assign line     = line_reg;
  assign last_bit = last_reg;
  assign penult   = (cnt_reg == LEN_W'(1));

endmodule

// File: rtl/master_arb_port.sv
// Master-side front end of the serial arbitration link: turns the core's
// parallel request into REQ/ID/ACK/NAK/END symbols and tracks bus ownership.
module master_arb_port
  import bus_arb_pkg::*;
#(
  parameter int ID_W        = 2,
  parameter int GNT_TIMEOUT = 64,
  parameter int COM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req,
  input  logic [ID_W-1:0] slave_id,
  input  logic            abort,
  input  logic            done,
  output logic            arb_line,
  input  logic            arb_grant,
  input  logic            arb_com,
  output logic            owned,
  output logic            busy,
  output logic            gnt_timeout,
  output logic            com_timeout,
  output logic            nak_sent
);

  localparam int SYM_W = max_int(3, ID_W);
  localparam int LEN_W = $clog2(SYM_W + 1);
  localparam int CNT_W = $clog2(max_int(GNT_TIMEOUT, COM_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] GNT_LAST = CNT_W'(GNT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GNT_PRE  = CNT_W'(GNT_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] COM_LAST = CNT_W'(COM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] COM_PRE  = CNT_W'(COM_TIMEOUT - 2);

  port_state_t      state_reg;
  logic [ID_W-1:0]  id_reg;
  logic             abort_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             owned_reg;
  logic             busy_reg;
  logic             gnt_timeout_reg;
  logic             com_timeout_reg;
  logic             nak_sent_reg;

  logic             sh_load;
  logic [SYM_W-1:0] sh_sym;
  logic [LEN_W-1:0] sh_len;
  logic             sh_line;
  logic             sh_last;
  logic             sh_penult;
  logic             abort_hit;

  assign abort_hit = abort_reg | abort;

  // END only sends the trailing '1'; the idle XFER line supplies the leading '0'.
  always_comb begin
    sh_load = 1'b0;
    sh_sym  = '0;
    sh_len  = '0;
    case (state_reg)
      IDLE: if (req && !abort) begin
        sh_load = 1'b1;
        sh_sym  = SYM_W'(SYM_REQ);
        sh_len  = LEN_W'(3);
      end
      REQ: if (sh_last) begin
        sh_load = 1'b1;
        sh_sym  = SYM_W'(id_reg);
        sh_len  = LEN_W'(ID_W);
      end
      WAIT_GNT: if (arb_grant) begin
        sh_load = 1'b1;
        sh_sym  = abort_hit ? SYM_W'(SYM_NAK) : SYM_W'(SYM_ACK);
        sh_len  = LEN_W'(3);
      end
      XFER: if (done) begin
        sh_load = 1'b1;
        sh_sym  = SYM_W'(SYM_END);
        sh_len  = LEN_W'(1);
      end
      default: ;
    endcase
  end

  sym_shifter #(
    .W     (SYM_W),
    .LEN_W (LEN_W)
  ) u_shifter (
    .clk      (clk),
    .rstn     (rstn),
    .load     (sh_load),
    .sym      (sh_sym),
    .len      (sh_len),
    .line     (sh_line),
    .last_bit (sh_last),
    .penult   (sh_penult)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      id_reg          <= '0;
      abort_reg       <= 1'b0;
      cnt_reg         <= '0;
      owned_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      gnt_timeout_reg <= 1'b0;
      com_timeout_reg <= 1'b0;
      nak_sent_reg    <= 1'b0;
    end else begin
      gnt_timeout_reg <= 1'b0;
      com_timeout_reg <= 1'b0;
      nak_sent_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          abort_reg <= 1'b0;
          if (req && !abort) begin
            id_reg    <= slave_id;
            state_reg <= REQ;
            busy_reg  <= 1'b1;
          end
        end
        REQ: begin
          if (abort) abort_reg <= 1'b1;
          if (sh_last) state_reg <= ID;
        end
        ID: begin
          if (abort) abort_reg <= 1'b1;
          if (sh_last) begin
            state_reg <= WAIT_GNT;
            cnt_reg   <= '0;
          end
        end
        WAIT_GNT: begin
          if (arb_grant) begin
            state_reg <= abort_hit ? NAK : ACK;
          end else begin
            if (abort) abort_reg <= 1'b1;
            if (cnt_reg != GNT_LAST) cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == GNT_PRE) gnt_timeout_reg <= 1'b1;
          end
        end
        ACK: if (sh_last) begin
          state_reg <= WAIT_COM;
          cnt_reg   <= '0;
        end
        NAK: begin
          if (sh_penult) nak_sent_reg <= 1'b1;
          if (sh_last) state_reg <= WAIT_REL;
        end
        WAIT_COM: begin
          if (arb_com) begin
            state_reg <= XFER;
            owned_reg <= 1'b1;
          end else if (!arb_grant) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            if (cnt_reg != COM_LAST) cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == COM_PRE) com_timeout_reg <= 1'b1;
          end
        end
        XFER: begin
          // A finished transfer still announces END even if the grant drops.
          if (done) begin
            state_reg <= END;
            owned_reg <= 1'b0;
          end else if (!arb_grant || !arb_com) begin
            state_reg <= WAIT_REL;
            owned_reg <= 1'b0;
          end
        end
        END: state_reg <= WAIT_REL;
        WAIT_REL: if (!arb_grant && !arb_com) begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          owned_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign arb_line    = sh_line;
  assign owned       = owned_reg;
  assign busy        = busy_reg;
  assign gnt_timeout = gnt_timeout_reg;
  assign com_timeout = com_timeout_reg;
  assign nak_sent    = nak_sent_reg;

endmodule

// File: tb/tb_master_arb_port.sv
// Directed bench for master_arb_port: walks request, grant, transfer, timeout,
// abort/NAK, grant-drop and mid-request reset sequences against fixed patterns.
module tb_master_arb_port;

  logic       clk;
  logic       rstn;
  logic       req;
  logic [1:0] slave_id;
  logic       abort;
  logic       done;
  logic       arb_line;
  logic       arb_grant;
  logic       arb_com;
  logic       owned;
  logic       busy;
  logic       gnt_timeout;
  logic       com_timeout;
  logic       nak_sent;

  int checks = 0;
  int errors = 0;

  master_arb_port dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .slave_id    (slave_id),
    .abort       (abort),
    .done        (done),
    .arb_line    (arb_line),
    .arb_grant   (arb_grant),
    .arb_com     (arb_com),
    .owned       (owned),
    .busy        (busy),
    .gnt_timeout (gnt_timeout),
    .com_timeout (com_timeout),
    .nak_sent    (nak_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Checks arb_line over n cycles, bits[n-1] first, advancing one cycle per bit.
  task automatic line_seq(input string tag, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      check(tag, arb_line, bits[i]);
      step();
    end
  endtask

  task automatic start_req(input logic [1:0] id);
    slave_id = id;
    req      = 1'b1;
    check("idle_line", arb_line, 1'b0);
    step();
    req = 1'b0;
  endtask

  initial begin
    logic [2:0] nak_line;
    logic [2:0] nak_flag;
    nak_line = 3'b110;
    nak_flag = 3'b001;

    rstn = 1'b0; req = 1'b0; slave_id = 2'b00; abort = 1'b0; done = 1'b0;
    arb_grant = 1'b0; arb_com = 1'b0;
    step();
    check("rst_line", arb_line, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_owned", owned, 1'b0);
    check("rst_gto", gnt_timeout, 1'b0);
    check("rst_cto", com_timeout, 1'b0);
    check("rst_nak", nak_sent, 1'b0);
    rstn = 1'b1;
    step();
    $display("txn reset checked");

    // req together with abort must not start a request
    req = 1'b1; abort = 1'b1;
    step();
    check("reqabort_busy", busy, 1'b0);
    check("reqabort_line", arb_line, 1'b0);
    req = 1'b0; abort = 1'b0;
    step();
    $display("txn req+abort ignored");

    // Normal request to slave 2'b10, grant after four wait cycles
    start_req(2'b10);
    check("s1_busy", busy, 1'b1);
    line_seq("s1_req_id", 16'b1111_0000, 8);
    check("s1_wait_line", arb_line, 1'b0);
    arb_grant = 1'b1;
    step();
    line_seq("s1_ack", 16'b101, 3);
    check("s1_wcom_line", arb_line, 1'b0);
    check("s1_wcom_owned", owned, 1'b0);
    arb_com = 1'b1;
    step();
    check("s1_owned", owned, 1'b1);
    check("s1_xfer_busy", busy, 1'b1);
    check("s1_xfer_line", arb_line, 1'b0);
    $display("txn request/grant/xfer slave=10");

    // done together with a grant drop: END still sent
    done = 1'b1; arb_grant = 1'b0;
    step();
    done = 1'b0;
    check("s2_end_line", arb_line, 1'b1);
    check("s2_end_owned", owned, 1'b0);
    slave_id = 2'b01; req = 1'b1;
    step();
    check("s2_rel_line", arb_line, 1'b0);
    check("s2_rel_busy", busy, 1'b1);
    arb_com = 1'b0;
    step();
    check("s2_idle_busy", busy, 1'b0);
    check("s2_idle_line", arb_line, 1'b0);
    req = 1'b0;
    step();
    check("s2_noreq_busy", busy, 1'b0);
    $display("txn done/end with grant drop");

    // Grant withheld 70 cycles: one timeout pulse at wait cycle 64
    start_req(2'b01);
    line_seq("s3_req_id", 16'b11101, 5);
    for (int k = 1; k <= 70; k++) begin
      check($sformatf("s3_gto_c%0d", k), gnt_timeout, (k == 64));
      step();
    end
    check("s3_wait_busy", busy, 1'b1);
    arb_grant = 1'b1;
    step();
    line_seq("s3_ack", 16'b101, 3);
    for (int j = 1; j <= 20; j++) begin
      check($sformatf("s3_cto_c%0d", j), com_timeout, (j == 16));
      step();
    end
    check("s3_wcom_owned", owned, 1'b0);
    arb_grant = 1'b0;
    step();
    check("s3_rej_busy", busy, 1'b0);
    check("s3_rej_owned", owned, 1'b0);
    $display("txn grant and com timeouts, grant drop in WAIT_COM");

    // abort during ID, later grant answered with NAK
    start_req(2'b11);
    line_seq("s4_req", 16'b111, 3);
    abort = 1'b1;
    line_seq("s4_id", 16'b11, 2);
    abort = 1'b0;
    check("s4_wait_line", arb_line, 1'b0);
    arb_grant = 1'b1;
    step();
    for (int i = 2; i >= 0; i--) begin
      check("s4_nak_line", arb_line, nak_line[i]);
      check("s4_nak_flag", nak_sent, nak_flag[i]);
      check("s4_nak_owned", owned, 1'b0);
      step();
    end
    check("s4_rel_line", arb_line, 1'b0);
    check("s4_rel_nak", nak_sent, 1'b0);
    check("s4_rel_busy", busy, 1'b1);
    arb_grant = 1'b0;
    step();
    check("s4_idle_busy", busy, 1'b0);
    check("s4_idle_owned", owned, 1'b0);
    $display("txn abort -> NAK");

    // Grant drop during XFER
    start_req(2'b00);
    line_seq("s5_req_id", 16'b11100, 5);
    arb_grant = 1'b1;
    step();
    line_seq("s5_ack", 16'b101, 3);
    arb_com = 1'b1;
    step();
    check("s5_owned", owned, 1'b1);
    arb_grant = 1'b0;
    step();
    check("s5_drop_owned", owned, 1'b0);
    check("s5_drop_busy", busy, 1'b1);
    check("s5_drop_line", arb_line, 1'b0);
    arb_com = 1'b0;
    step();
    check("s5_idle_busy", busy, 1'b0);
    $display("txn grant drop in XFER");

    // Reset asserted in the middle of the REQ preamble
    start_req(2'b10);
    check("s6_req_line", arb_line, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("s6_rst_line", arb_line, 1'b0);
    check("s6_rst_busy", busy, 1'b0);
    step();
    rstn = 1'b1;
    check("s6_post_line", arb_line, 1'b0);
    step();
    start_req(2'b10);
    line_seq("s6_restart", 16'b11110, 5);
    check("s6_restart_busy", busy, 1'b1);
    $display("txn mid-REQ reset and restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/master_arb_port.md
Name: master_arb_port

Overview:
- Master-side front end of the two-master serial bus arbitration link; one instance per master.
- Sits directly upstream of the bus arbiter.
- Converts the master core's parallel bus request (target slave id, go/abort, transfer-done) into the 1-bit serial request/ack/nak/end symbol stream the arbiter samples.
- Tracks the arbiter's grant and communication-enable lines and reports ownership back to the core.

Parameters:
- ID_W, 2, width of slave id; sent MSB first.
- GNT_TIMEOUT, 64, cycles waiting for grant before pulsing gnt_timeout; must be >= 2.
- COM_TIMEOUT, 16, cycles after ack waiting for arb_com before pulsing com_timeout; must be >= 2.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- req  input  1  core requests the bus; level, sampled in IDLE
- slave_id  input  ID_W  target slave; captured when req is accepted
- abort  input  1  core withdraws the request; a later grant is answered with NAK
- done  input  1  core finished transfer; 1-cycle pulse, honoured only in XFER
- arb_line  output  1  serial symbol line to arbiter (arbiter's m_in)
- arb_grant  input  1  grant from arbiter (arbiter's m_out)
- arb_com  input  1  communication enabled by arbiter (arbiter's com_m)
- owned  output  1  high while in XFER; core may drive the bus mux path
- busy  output  1  high in every state except IDLE
- gnt_timeout  output  1  1-cycle pulse at GNT_TIMEOUT expiry
- com_timeout  output  1  1-cycle pulse at COM_TIMEOUT expiry
- nak_sent  output  1  1-cycle pulse on the last NAK symbol bit

Behaviour:
- Reset (async, rstn=0): state IDLE, arb_line=0, owned=0, busy=0, all pulses 0, counters 0, captured id 0.
- arb_line is registered. Each value below appears for exactly one clk, starting the cycle after the state is entered.
- IDLE: arb_line=0. If req=1 and abort=0, capture slave_id and go to REQ.
- REQ: drive 1,1,1 (3 cycles), then go to ID.
- ID: drive slave_id MSB..LSB (ID_W cycles), then go to WAIT_GNT. Request-to-line latency: first 1 appears 1 cycle after req is sampled.
- WAIT_GNT: arb_line=0; timeout counter runs.
  - arb_grant=1 and no abort latched: go to ACK.
  - arb_grant=1 and abort latched: go to NAK.
  - Counter reaches GNT_TIMEOUT-1: pulse gnt_timeout, keep waiting, counter saturates (no repeat pulse).
  - abort is sticky from REQ onward until return to IDLE.
- ACK: drive 1,0,1, then go to WAIT_COM.
- NAK: drive 1,1,0 with nak_sent on the third cycle, then go to WAIT_REL.
- WAIT_COM: arb_line=0.
  - arb_com=1: go to XFER.
  - arb_grant falls first (arbiter rejected): go to IDLE.
  - COM_TIMEOUT expiry: pulse com_timeout once, keep waiting.
- XFER: owned=1, arb_line=0.
  - done=1: go to END.
  - arb_grant or arb_com dropping while in XFER: go to WAIT_REL, owned deasserts next cycle.
  - abort is ignored in XFER.
- END: arb_line=1 for one cycle. Preceded by 0, this forms the "01" end pattern. Then go to WAIT_REL.
- WAIT_REL: arb_line=0. Wait for arb_grant=0 and arb_com=0, then go to IDLE. A new req cannot be accepted before IDLE.
- Simultaneous events:
  - req and abort together in IDLE: no request.
  - done and a grant drop in XFER: END takes priority; the symbol is still sent.
- Mid-operation reset: immediate return to reset values, line forced 0 asynchronously.
- Counters are $clog2(max timeout)+1 bits wide and saturate; never wrap.

Decomposition:
- Shared package bus_arb_pkg holds:
  - state enum port_state_t {IDLE, REQ, ID, WAIT_GNT, ACK, NAK, WAIT_COM, XFER, END, WAIT_REL};
  - symbol constants SYM_REQ=3'b111, SYM_ACK=3'b101, SYM_NAK=3'b110, SYM_END=2'b01; the arbiter reuses these.
- One sub-module: sym_shifter, a loadable parallel-to-serial register with bit counter. It is loaded with symbol+length, shifts MSB first, and raises last_bit. REQ, ID, ACK, NAK and END all use it.

Test Plan:
- req=1, slave_id=2'b10, arb_grant raised 4 cycles after ID -> arb_line 0,1,1,1,1,0,0...; after grant 1,0,1; arb_com=1 -> owned=1 next cycle.
- In XFER pulse done -> arb_line 0 then 1 for one cycle; arbiter drops grant/com -> busy=0, state IDLE.
- Grant withheld for 70 cycles (GNT_TIMEOUT=64) -> single gnt_timeout pulse at wait cycle 64; later grant -> normal ACK 1,0,1.
- abort during ID, then grant -> arb_line 1,1,0, nak_sent on third bit, owned never high, IDLE after grant falls.
- Grant then grant drop in WAIT_COM -> IDLE, no owned; drop in XFER -> owned falls, WAIT_REL, IDLE.
- rstn low mid-REQ -> arb_line 0 within the same cycle, busy=0; after release, new req restarts the full 1,1,1 preamble.
